// File: rtl/ibuf_vec.sv
// +----------------------------------------------------------------------------+
// | ibuf_vec : double-buffered input vector buffer for CIM crossbar row drivers |
// | Optional macro IBUF_ZERO_PAD_EN: i_last ends a vector early, zero-padded.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ibuf_vec #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 5,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DEPTH*DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]        o_count
);

  localparam logic [0:0] c_filling = 1'b0;
  localparam logic [0:0] c_full    = 1'b1;
  localparam logic [0:0] c_empty   = 1'b0;
  localparam logic [0:0] c_valid   = 1'b1;

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);

  logic [0:0]              fill_q, fill_d;
  logic [0:0]              out_q, out_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DEPTH*DATA_W-1:0] bank_q, bank_d;
  logic [DEPTH*DATA_W-1:0] obank_q, obank_d;

  logic                    w_accept;
  logic                    w_out_free;
  logic                    w_complete;
  logic                    w_load_direct;
  logic                    w_load_full;
  logic [DEPTH*DATA_W-1:0] w_merged;

  assign w_accept   = i_valid && (fill_q == c_filling);
  assign w_out_free = (out_q == c_empty) || i_ready;

`ifdef IBUF_ZERO_PAD_EN
  assign w_complete = w_accept && ((count_q == c_last_idx) || i_last);
`else
  logic w_unused_last;
  assign w_unused_last = i_last;
  assign w_complete    = w_accept && (count_q == c_last_idx);
`endif

  assign w_load_direct = w_complete && w_out_free;
  assign w_load_full   = (fill_q == c_full) && w_out_free;

  // Fill bank with the incoming word already placed at the current slot
  always_comb begin
    w_merged = bank_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (count_q == CNT_W'(k)) begin
        w_merged[k*DATA_W +: DATA_W] = i_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q  <= c_filling;
      out_q   <= c_empty;
      count_q <= '0;
    end else begin
      fill_q  <= fill_d;
      out_q   <= out_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    fill_d  = fill_q;
    out_d   = out_q;
    count_d = count_q;
    case (fill_q)
      c_filling: begin
        if (w_complete) begin
          if (w_out_free) begin
            count_d = '0;
          end else begin
            fill_d  = c_full;
            count_d = c_depth;
          end
        end else if (w_accept) begin
          count_d = count_q + 1'b1;
        end
      end
      c_full: begin
        if (w_out_free) begin
          fill_d  = c_filling;
          count_d = '0;
        end
      end
      default: fill_d = c_filling;
    endcase
    if (w_load_direct || w_load_full) begin
      out_d = c_valid;
    end else if ((out_q == c_valid) && i_ready) begin
      out_d = c_empty;
    end
  end

  always_comb begin
    o_ready = (fill_q == c_filling);
    o_valid = (out_q == c_valid);
    o_count = count_q;
    o_data  = obank_q;
  end

  always_comb begin
    bank_d  = bank_q;
    obank_d = obank_q;
    if (w_accept) begin
      bank_d = w_merged;
    end
`ifdef IBUF_ZERO_PAD_EN
    // Clearing on transfer makes unwritten slots of a short vector read as 0
    if (w_load_direct || w_load_full) begin
      bank_d = '0;
    end
`endif
    if (w_load_direct) begin
      obank_d = w_merged;
    end else if (w_load_full) begin
      obank_d = bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q  <= '0;
      obank_q <= '0;
    end else begin
      bank_q  <= bank_d;
      obank_q <= obank_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ibuf_vec.sv
// +----------------------------------------------------------------------------+
// | tb_ibuf_vec : directed self-checking bench for ibuf_vec                    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ibuf_vec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_valid = 1'b0;
  logic [7:0]  a_data = '0;
  logic        a_last = 1'b0;
  logic        a_iready = 1'b0;
  logic        a_oready;
  logic        a_ovalid;
  logic [39:0] a_odata;
  logic [2:0]  a_count;

  logic        b_valid = 1'b0;
  logic [15:0] b_data = '0;
  logic        b_last = 1'b0;
  logic        b_iready = 1'b0;
  logic        b_oready;
  logic        b_ovalid;
  logic [15:0] b_odata;
  logic [0:0]  b_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ibuf_vec #(.DATA_W(8), .DEPTH(5)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_valid(a_valid), .o_ready(a_oready), .i_data(a_data), .i_last(a_last),
    .o_valid(a_ovalid), .i_ready(a_iready), .o_data(a_odata), .o_count(a_count)
  );

  ibuf_vec #(.DATA_W(16), .DEPTH(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_valid(b_valid), .o_ready(b_oready), .i_data(b_data), .i_last(b_last),
    .o_valid(b_ovalid), .i_ready(b_iready), .o_data(b_odata), .o_count(b_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    a_valid = 1'b0; a_last = 1'b0; a_iready = 1'b0;
    b_valid = 1'b0; b_iready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++;
    if ({a_ovalid, a_oready, a_count} !== {1'b0, 1'b1, 3'd0})
      $display("FAIL reset_ctrl: got valid=%b ready=%b count=%0d want 0 1 0", a_ovalid, a_oready, a_count);
    else pass_cnt++;
    total_cnt++;
    if (a_odata !== 40'h0) $display("FAIL reset_data: got %h want 0", a_odata);
    else pass_cnt++;
    total_cnt++;
    if ({b_ovalid, b_oready, b_count} !== {1'b0, 1'b1, 1'b0})
      $display("FAIL reset_b: got valid=%b ready=%b count=%0d want 0 1 0", b_ovalid, b_oready, b_count);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [2:0] exp_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    apply_reset();
    a_iready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1;
      a_data  = 8'((i + 1) * 8'h11);
      tick();
      total_cnt++;
      if (a_count !== exp_cnt[i]) $display("FAIL single_count%0d: got %0d want %0d", i, a_count, exp_cnt[i]);
      else pass_cnt++;
    end
    a_valid = 1'b0;
    total_cnt++;
    if (a_ovalid !== 1'b1 || a_odata !== 40'h5544332211)
      $display("FAIL single_vec: got valid=%b data=%h want 1 5544332211", a_ovalid, a_odata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_ovalid !== 1'b0) $display("FAIL single_drain: got valid=%b want 0", a_ovalid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      a_valid = 1'b1;
      a_data  = 8'(i);
      tick();
    end
    total_cnt++;
    if ({a_oready, a_ovalid, a_count} !== {1'b0, 1'b1, 3'd5} || a_odata !== 40'h0504030201)
      $display("FAIL bp_full: got ready=%b valid=%b count=%0d data=%h want 0 1 5 0504030201",
               a_oready, a_ovalid, a_count, a_odata);
    else pass_cnt++;
    a_data = 8'h0B;
    tick();
    total_cnt++;
    if ({a_oready, a_count} !== {1'b0, 3'd5} || a_odata !== 40'h0504030201)
      $display("FAIL bp_hold: got ready=%b count=%0d data=%h want 0 5 0504030201", a_oready, a_count, a_odata);
    else pass_cnt++;
    a_iready = 1'b1;
    tick();
    a_iready = 1'b0;
    total_cnt++;
    if ({a_oready, a_ovalid, a_count} !== {1'b1, 1'b1, 3'd0} || a_odata !== 40'h0A09080706)
      $display("FAIL bp_release: got ready=%b valid=%b count=%0d data=%h want 1 1 0 0a09080706",
               a_oready, a_ovalid, a_count, a_odata);
    else pass_cnt++;
    tick();
    a_valid = 1'b0;
    total_cnt++;
    if (a_count !== 3'd1 || a_odata !== 40'h0A09080706)
      $display("FAIL bp_word11: got count=%0d data=%h want 1 0a09080706", a_count, a_odata);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int          nvec = 0;
    logic [39:0] exp;
    logic        stall = 1'b0;
    logic        bad = 1'b0;
    apply_reset();
    a_iready = 1'b1;
    a_valid  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      a_data = 8'(k);
      if (a_oready !== 1'b1) stall = 1'b1;
      tick();
      if (a_ovalid !== (k % 5 == 0)) bad = 1'b1;
      if (k % 5 == 0) begin
        nvec++;
        for (int e = 0; e < 5; e++) exp[e*8 +: 8] = 8'(k - 4 + e);
        total_cnt++;
        if (a_odata !== exp) $display("FAIL b2b_vec%0d: got %h want %h", nvec, a_odata, exp);
        else pass_cnt++;
      end
    end
    a_valid = 1'b0;
    total_cnt++;
    if (stall !== 1'b0 || bad !== 1'b0)
      $display("FAIL b2b_timing: got stall=%b valid_pattern_err=%b want 0 0", stall, bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      a_valid = 1'b1;
      a_data  = 8'(8'h20 + i);
      tick();
    end
    a_valid = 1'b0;
    total_cnt++;
    if (a_ovalid !== 1'b1 || a_count !== 3'd3)
      $display("FAIL midrst_pre: got valid=%b count=%0d want 1 3", a_ovalid, a_count);
    else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total_cnt++;
    if ({a_ovalid, a_oready, a_count} !== {1'b0, 1'b1, 3'd0} || a_odata !== 40'h0)
      $display("FAIL midrst: got valid=%b ready=%b count=%0d data=%h want 0 1 0 0",
               a_ovalid, a_oready, a_count, a_odata);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_zero_pad();
    apply_reset();
    a_valid = 1'b1;
    a_data  = 8'hAA;
    tick();
    a_data  = 8'hBB;
    a_last  = 1'b1;
    tick();
    a_valid = 1'b0;
    a_last  = 1'b0;
    total_cnt++;
`ifdef IBUF_ZERO_PAD_EN
    if (a_ovalid !== 1'b1 || a_count !== 3'd0 || a_odata !== 40'h000000BBAA)
      $display("FAIL zpad: got valid=%b count=%0d data=%h want 1 0 000000bbaa", a_ovalid, a_count, a_odata);
    else pass_cnt++;
`else
    if (a_ovalid !== 1'b0 || a_count !== 3'd2)
      $display("FAIL zpad_off: got valid=%b count=%0d want 0 2", a_ovalid, a_count);
    else pass_cnt++;
`endif
  endtask

  task automatic test_depth1();
    logic [15:0] exp [8];
    int          tx = 0;
    int          rx = 0;
    logic        acc, cons;
    apply_reset();
    for (int i = 0; i < 8; i++) exp[i] = 16'h1000 + 16'(i * 16'h0111);
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      b_valid  = (tx < 8);
      b_data   = (tx < 8) ? exp[tx] : 16'h0;
      b_iready = cyc[0];
      acc  = b_valid && b_oready;
      cons = b_ovalid && b_iready;
      if (cons) begin
        total_cnt++;
        if (b_odata !== exp[rx]) $display("FAIL d1_word%0d: got %h want %h", rx, b_odata, exp[rx]);
        else pass_cnt++;
        rx++;
      end
      tick();
      if (acc) tx++;
    end
    b_valid  = 1'b0;
    b_iready = 1'b0;
    total_cnt++;
    if (rx !== 8) $display("FAIL d1_count: got %0d words want 8", rx);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_zero_pad();
    test_depth1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
